// File: rtl/tone_arbiter_pkg.sv
// Shared field widths, requester indices and the arbiter state type for the
// tone engine arbiter.
package tone_arbiter_pkg;

  localparam int OCTAVE_BITS = 3;
  localparam int NOTE_BITS   = 3;
  localparam int LENGTH_BITS = 3;
  localparam int NUM_REQ     = 3;

  localparam logic [1:0] REQ_LIVE   = 2'd0;
  localparam logic [1:0] REQ_REPLAY = 2'd1;
  localparam logic [1:0] REQ_SONG   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_ARM   = 3'd2,
    ST_PLAY  = 3'd3,
    ST_DONE  = 3'd4,
    ST_GAP   = 3'd5
  } arb_state_t;

endpackage

// File: rtl/tone_arbiter_prio_pick3.sv
// Fixed-priority selector: lowest set request bit wins, returned both one-hot
// and as a requester index for the data mux.
module prio_pick3
  import tone_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] pick,
  output logic [1:0]         idx,
  output logic               valid
);

  // Lowest-set-bit priority encode.
  always_comb begin
    pick  = 3'b000;
    idx   = REQ_LIVE;
    valid = 1'b0;
    if (req[0]) begin
      pick  = 3'b001;
      idx   = REQ_LIVE;
      valid = 1'b1;
    end else if (req[1]) begin
      pick  = 3'b010;
      idx   = REQ_REPLAY;
      valid = 1'b1;
    end else if (req[2]) begin
      pick  = 3'b100;
      idx   = REQ_SONG;
      valid = 1'b1;
    end else begin
      pick  = 3'b000;
      idx   = REQ_LIVE;
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/tone_arbiter.sv
// Non-preemptive arbiter sharing the tone engine between live play, record
// replay and song playback, with engine start timeout and inter-note rest.
module tone_arbiter
  import tone_arbiter_pkg::*;
#(
  parameter int OCT_W         = OCTAVE_BITS,
  parameter int NOTE_W        = NOTE_BITS,
  parameter int LEN_W         = LENGTH_BITS,
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      abort,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*OCT_W-1:0]  req_oct,
  input  logic [NUM_REQ*NOTE_W-1:0] req_note,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic                      aborted,
  output logic                      timeout,
  output logic                      snd_en,
  output logic [OCT_W-1:0]          snd_oct,
  output logic [NOTE_W-1:0]         snd_note,
  output logic [LEN_W-1:0]          snd_len,
  input  logic                      snd_over,
  output logic                      busy
);

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TO_W  = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((START_TIMEOUT > 1) ? START_TIMEOUT - 1 : 0);

  arb_state_t          state_r, state_nxt_s, rest_state_s;
  logic [NUM_REQ-1:0]  gnt_r, gnt_nxt_s, done_r, done_nxt_s;
  logic                aborted_r, aborted_nxt_s, timeout_r, timeout_nxt_s;
  logic                snd_en_r, snd_en_nxt_s, busy_r, load_s;
  logic [OCT_W-1:0]    snd_oct_r, sel_oct_s;
  logic [NOTE_W-1:0]   snd_note_r, sel_note_s;
  logic [LEN_W-1:0]    snd_len_r, sel_len_s;
  logic [GAP_W-1:0]    gap_cnt_r, gap_cnt_nxt_s;
  logic [TO_W-1:0]     to_cnt_r, to_cnt_nxt_s;
  logic [NUM_REQ-1:0]  pick_s;
  logic [1:0]          idx_s;
  logic                valid_s;

  prio_pick3 u_pick (
    .req   (req),
    .pick  (pick_s),
    .idx   (idx_s),
    .valid (valid_s)
  );

  // Route the winning requester's note fields toward the latch.
  always_comb begin
    sel_oct_s  = req_oct[0 +: OCT_W];
    sel_note_s = req_note[0 +: NOTE_W];
    sel_len_s  = req_len[0 +: LEN_W];
    case (idx_s)
      REQ_REPLAY: begin
        sel_oct_s  = req_oct[OCT_W +: OCT_W];
        sel_note_s = req_note[NOTE_W +: NOTE_W];
        sel_len_s  = req_len[LEN_W +: LEN_W];
      end
      REQ_SONG: begin
        sel_oct_s  = req_oct[2*OCT_W +: OCT_W];
        sel_note_s = req_note[2*NOTE_W +: NOTE_W];
        sel_len_s  = req_len[2*LEN_W +: LEN_W];
      end
      default: begin
        sel_oct_s  = req_oct[0 +: OCT_W];
        sel_note_s = req_note[0 +: NOTE_W];
        sel_len_s  = req_len[0 +: LEN_W];
      end
    endcase
  end

  // Next-state and next-output decode; cancellation by en or abort overrides
  // every in-flight transition, including a coincident snd_over rise.
  always_comb begin
    state_nxt_s   = state_r;
    gnt_nxt_s     = gnt_r;
    done_nxt_s    = 3'b000;
    aborted_nxt_s = 1'b0;
    timeout_nxt_s = 1'b0;
    snd_en_nxt_s  = snd_en_r;
    gap_cnt_nxt_s = gap_cnt_r;
    to_cnt_nxt_s  = to_cnt_r;
    load_s        = 1'b0;
    if (GAP_CYCLES > 0) begin
      rest_state_s = ST_GAP;
    end else begin
      rest_state_s = ST_IDLE;
    end

    case (state_r)
      ST_IDLE: begin
        snd_en_nxt_s = 1'b0;
        if (en && valid_s) begin
          state_nxt_s = ST_GRANT;
          gnt_nxt_s   = pick_s;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
          gnt_nxt_s   = 3'b000;
        end
      end
      ST_GAP: begin
        snd_en_nxt_s = 1'b0;
        if (!en || (gap_cnt_r >= GAP_LAST)) begin
          state_nxt_s   = ST_IDLE;
          gap_cnt_nxt_s = '0;
        end else begin
          gap_cnt_nxt_s = gap_cnt_r + GAP_W'(1);
        end
      end
      ST_GRANT, ST_ARM, ST_PLAY, ST_DONE: begin
        if (!en || abort) begin
          aborted_nxt_s = 1'b1;
          gnt_nxt_s     = 3'b000;
          snd_en_nxt_s  = 1'b0;
          if (en) begin
            state_nxt_s = rest_state_s;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          case (state_r)
            ST_GRANT: begin
              snd_en_nxt_s = 1'b1;
              to_cnt_nxt_s = '0;
              state_nxt_s  = ST_ARM;
            end
            ST_ARM: begin
              if (!snd_over) begin
                state_nxt_s = ST_PLAY;
              end else if (to_cnt_r >= TO_LAST) begin
                timeout_nxt_s = 1'b1;
                aborted_nxt_s = 1'b1;
                gnt_nxt_s     = 3'b000;
                snd_en_nxt_s  = 1'b0;
                state_nxt_s   = rest_state_s;
              end else begin
                to_cnt_nxt_s = to_cnt_r + TO_W'(1);
              end
            end
            ST_PLAY: begin
              if (snd_over) begin
                state_nxt_s = ST_DONE;
              end else begin
                state_nxt_s = ST_PLAY;
              end
            end
            default: begin
              done_nxt_s   = gnt_r;
              gnt_nxt_s    = 3'b000;
              snd_en_nxt_s = 1'b0;
              state_nxt_s  = rest_state_s;
            end
          endcase
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        gnt_nxt_s    = 3'b000;
        snd_en_nxt_s = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      gnt_r      <= 3'b000;
      done_r     <= 3'b000;
      aborted_r  <= 1'b0;
      timeout_r  <= 1'b0;
      snd_en_r   <= 1'b0;
      busy_r     <= 1'b0;
      snd_oct_r  <= '0;
      snd_note_r <= '0;
      snd_len_r  <= '0;
      gap_cnt_r  <= '0;
      to_cnt_r   <= '0;
    end else begin
      state_r   <= state_nxt_s;
      gnt_r     <= gnt_nxt_s;
      done_r    <= done_nxt_s;
      aborted_r <= aborted_nxt_s;
      timeout_r <= timeout_nxt_s;
      snd_en_r  <= snd_en_nxt_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
      gap_cnt_r <= gap_cnt_nxt_s;
      to_cnt_r  <= to_cnt_nxt_s;
      if (load_s) begin
        snd_oct_r  <= sel_oct_s;
        snd_note_r <= sel_note_s;
        snd_len_r  <= sel_len_s;
      end else begin
        snd_oct_r  <= snd_oct_r;
        snd_note_r <= snd_note_r;
        snd_len_r  <= snd_len_r;
      end
    end
  end

  assign gnt      = gnt_r;
  assign done     = done_r;
  assign aborted  = aborted_r;
  assign timeout  = timeout_r;
  assign snd_en   = snd_en_r;
  assign snd_oct  = snd_oct_r;
  assign snd_note = snd_note_r;
  assign snd_len  = snd_len_r;
  assign busy     = busy_r;

endmodule
